// File: rtl/tl_fifo_ordered_fixer.sv
// TileLink A/D FIFO-ordering fixer: per-source domain tracking stalls first A beats that could reorder D; zero-latency pass-through.
// A is held only by stall (never by D or ready); D is never held. Optional TL_FIFO_FIXER_PERF_EN adds perf_stall_cycles.
module tl_fifo_ordered_fixer #(
  parameter int SOURCE_W     = 5,
  parameter int ADDR_W       = 31,
  parameter int DATA_W       = 64,
  parameter int NUM_DOMAINS  = 4,
  parameter int DOMAIN_LSB   = 28,
  parameter int MAX_INFLIGHT = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  auto_in_a_valid,
  output logic                  auto_in_a_ready,
  input  logic [2:0]            auto_in_a_bits_opcode,
  input  logic [2:0]            auto_in_a_bits_param,
  input  logic [2:0]            auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0]   auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]     auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0]   auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]     auto_in_a_bits_data,
  input  logic                  auto_in_a_bits_corrupt,
  output logic                  auto_out_a_valid,
  input  logic                  auto_out_a_ready,
  output logic [2:0]            auto_out_a_bits_opcode,
  output logic [2:0]            auto_out_a_bits_param,
  output logic [2:0]            auto_out_a_bits_size,
  output logic [SOURCE_W-1:0]   auto_out_a_bits_source,
  output logic [ADDR_W-1:0]     auto_out_a_bits_address,
  output logic [DATA_W/8-1:0]   auto_out_a_bits_mask,
  output logic [DATA_W-1:0]     auto_out_a_bits_data,
  output logic                  auto_out_a_bits_corrupt,
  input  logic                  auto_out_d_valid,
  output logic                  auto_out_d_ready,
  input  logic [2:0]            auto_out_d_bits_opcode,
  input  logic [1:0]            auto_out_d_bits_param,
  input  logic [2:0]            auto_out_d_bits_size,
  input  logic [SOURCE_W-1:0]   auto_out_d_bits_source,
  input  logic                  auto_out_d_bits_sink,
  input  logic                  auto_out_d_bits_denied,
  input  logic [DATA_W-1:0]     auto_out_d_bits_data,
  input  logic                  auto_out_d_bits_corrupt,
  output logic                  auto_in_d_valid,
  input  logic                  auto_in_d_ready,
  output logic [2:0]            auto_in_d_bits_opcode,
  output logic [1:0]            auto_in_d_bits_param,
  output logic [2:0]            auto_in_d_bits_size,
  output logic [SOURCE_W-1:0]   auto_in_d_bits_source,
  output logic                  auto_in_d_bits_sink,
  output logic                  auto_in_d_bits_denied,
  output logic [DATA_W-1:0]     auto_in_d_bits_data,
  output logic                  auto_in_d_bits_corrupt
`ifdef TL_FIFO_FIXER_PERF_EN
  ,output logic [31:0]          perf_stall_cycles
`endif
);

  localparam int LOG_BB = $clog2(DATA_W / 8);
  localparam int DOM_W  = $clog2(NUM_DOMAINS);
  localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int NSRC   = 1 << SOURCE_W;

  // Index of the final beat of a burst (0 for single-beat messages).
  function automatic logic [7:0] last_idx(input logic [2:0] size, input logic has_data);
    int sh;
    logic [7:0] r;
    r  = '0;
    sh = int'(size) - LOG_BB;
    if (has_data && sh > 0) r = 8'((32'd1 << sh) - 32'd1);
    return r;
  endfunction

  logic [CNT_W-1:0] cnt [NSRC];
  logic [DOM_W-1:0] dom [NSRC];
  logic [7:0]       a_beat;
  logic [7:0]       d_beat;

  logic [SOURCE_W-1:0] a_src;
  logic [SOURCE_W-1:0] d_src;
  logic [DOM_W-1:0]    a_dom;
  logic                a_first;
  logic                a_last;
  logic                d_last;
  logic                stall;
  logic                a_fire;
  logic                d_fire;
  logic                inc;
  logic                dec;
  logic                same_src;

  assign a_src   = auto_in_a_bits_source;
  assign d_src   = auto_out_d_bits_source;
  assign a_dom   = auto_in_a_bits_address[DOMAIN_LSB +: DOM_W];
  assign a_first = (a_beat == 8'd0);
  assign a_last  = (a_beat == last_idx(auto_in_a_bits_size, !auto_in_a_bits_opcode[2]));
  assign d_last  = (d_beat == last_idx(auto_out_d_bits_size, auto_out_d_bits_opcode[1:0] == 2'b01));

  // Only registered state and the A payload feed stall, so valid never depends on ready.
  assign stall = a_first &&
                 ((cnt[a_src] == CNT_W'(MAX_INFLIGHT)) ||
                  ((cnt[a_src] != '0) && (dom[a_src] != a_dom)));

  assign a_fire   = auto_in_a_valid && auto_in_a_ready;
  assign d_fire   = auto_out_d_valid && auto_in_d_ready;
  assign inc      = a_fire && a_first;
  // A response to an idle source is a protocol error and is ignored rather than wrapping.
  assign dec      = d_fire && d_last && (auto_out_d_bits_opcode != 3'd6) && (cnt[d_src] != '0);
  assign same_src = (a_src == d_src);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_beat <= '0;
      d_beat <= '0;
      for (int i = 0; i < NSRC; i++) begin
        cnt[i] <= '0;
        dom[i] <= '0;
      end
    end else begin
      if (a_fire) a_beat <= a_last ? 8'd0 : a_beat + 8'd1;
      if (d_fire) d_beat <= d_last ? 8'd0 : d_beat + 8'd1;
      if (inc) begin
        dom[a_src] <= a_dom;
        if (!(dec && same_src)) cnt[a_src] <= cnt[a_src] + 1'b1;
      end
      if (dec && !(inc && same_src)) cnt[d_src] <= cnt[d_src] - 1'b1;
    end
  end

`ifdef TL_FIFO_FIXER_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
    end else if (auto_in_a_valid && stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  assign auto_out_a_valid        = auto_in_a_valid & ~stall;
  assign auto_in_a_ready         = auto_out_a_ready & ~stall;
  assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
  assign auto_out_a_bits_param   = auto_in_a_bits_param;
  assign auto_out_a_bits_size    = auto_in_a_bits_size;
  assign auto_out_a_bits_source  = auto_in_a_bits_source;
  assign auto_out_a_bits_address = auto_in_a_bits_address;
  assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
  assign auto_out_a_bits_data    = auto_in_a_bits_data;
  assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

  assign auto_in_d_valid         = auto_out_d_valid;
  assign auto_out_d_ready        = auto_in_d_ready;
  assign auto_in_d_bits_opcode   = auto_out_d_bits_opcode;
  assign auto_in_d_bits_param    = auto_out_d_bits_param;
  assign auto_in_d_bits_size     = auto_out_d_bits_size;
  assign auto_in_d_bits_source   = auto_out_d_bits_source;
  assign auto_in_d_bits_sink     = auto_out_d_bits_sink;
  assign auto_in_d_bits_denied   = auto_out_d_bits_denied;
  assign auto_in_d_bits_data     = auto_out_d_bits_data;
  assign auto_in_d_bits_corrupt  = auto_out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_fifo_ordered_fixer.sv
// Bench for tl_fifo_ordered_fixer: directed A/D sequences, ready checked per cycle, pass-through payloads via scoreboard queues.
module tb_tl_fifo_ordered_fixer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        in_a_valid, in_a_ready, out_a_valid, out_a_ready;
  logic [2:0]  in_a_opcode, in_a_param, in_a_size;
  logic [4:0]  in_a_source;
  logic [30:0] in_a_address;
  logic [7:0]  in_a_mask;
  logic [63:0] in_a_data;
  logic        in_a_corrupt;
  logic [2:0]  out_a_opcode, out_a_param, out_a_size;
  logic [4:0]  out_a_source;
  logic [30:0] out_a_address;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_a_corrupt;
  logic        out_d_valid, out_d_ready, in_d_valid, in_d_ready;
  logic [2:0]  out_d_opcode, out_d_size, in_d_opcode, in_d_size;
  logic [1:0]  out_d_param, in_d_param;
  logic [4:0]  out_d_source, in_d_source;
  logic        out_d_sink, out_d_denied, out_d_corrupt;
  logic        in_d_sink, in_d_denied, in_d_corrupt;
  logic [63:0] out_d_data, in_d_data;
`ifdef TL_FIFO_FIXER_PERF_EN
  logic [31:0] perf;
`endif

  tl_fifo_ordered_fixer dut (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(in_a_valid), .auto_in_a_ready(in_a_ready),
    .auto_in_a_bits_opcode(in_a_opcode), .auto_in_a_bits_param(in_a_param),
    .auto_in_a_bits_size(in_a_size), .auto_in_a_bits_source(in_a_source),
    .auto_in_a_bits_address(in_a_address), .auto_in_a_bits_mask(in_a_mask),
    .auto_in_a_bits_data(in_a_data), .auto_in_a_bits_corrupt(in_a_corrupt),
    .auto_out_a_valid(out_a_valid), .auto_out_a_ready(out_a_ready),
    .auto_out_a_bits_opcode(out_a_opcode), .auto_out_a_bits_param(out_a_param),
    .auto_out_a_bits_size(out_a_size), .auto_out_a_bits_source(out_a_source),
    .auto_out_a_bits_address(out_a_address), .auto_out_a_bits_mask(out_a_mask),
    .auto_out_a_bits_data(out_a_data), .auto_out_a_bits_corrupt(out_a_corrupt),
    .auto_out_d_valid(out_d_valid), .auto_out_d_ready(out_d_ready),
    .auto_out_d_bits_opcode(out_d_opcode), .auto_out_d_bits_param(out_d_param),
    .auto_out_d_bits_size(out_d_size), .auto_out_d_bits_source(out_d_source),
    .auto_out_d_bits_sink(out_d_sink), .auto_out_d_bits_denied(out_d_denied),
    .auto_out_d_bits_data(out_d_data), .auto_out_d_bits_corrupt(out_d_corrupt),
    .auto_in_d_valid(in_d_valid), .auto_in_d_ready(in_d_ready),
    .auto_in_d_bits_opcode(in_d_opcode), .auto_in_d_bits_param(in_d_param),
    .auto_in_d_bits_size(in_d_size), .auto_in_d_bits_source(in_d_source),
    .auto_in_d_bits_sink(in_d_sink), .auto_in_d_bits_denied(in_d_denied),
    .auto_in_d_bits_data(in_d_data), .auto_in_d_bits_corrupt(in_d_corrupt)
`ifdef TL_FIFO_FIXER_PERF_EN
    ,.perf_stall_cycles(perf)
`endif
  );

  typedef struct packed {
    logic [2:0] op, param, size; logic [4:0] src; logic [30:0] addr;
    logic [7:0] mask; logic [63:0] data; logic corrupt;
  } a_t;
  typedef struct packed {
    logic [2:0] op; logic [1:0] param; logic [2:0] size; logic [4:0] src;
    logic sink, denied; logic [63:0] data; logic corrupt;
  } d_t;

  a_t a_q[$];
  d_t d_q[$];
  a_t got_a, exp_a;
  d_t got_d, exp_d;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic set_a(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src,
                       input logic [30:0] addr);
    a_t t;
    t = '{op: op, param: 3'd0, size: size, src: src, addr: addr, mask: 8'hFF,
          data: 64'({addr, 3'(op), src}), corrupt: 1'b0};
    in_a_valid = 1'b1; in_a_opcode = t.op; in_a_param = t.param; in_a_size = t.size;
    in_a_source = t.src; in_a_address = t.addr; in_a_mask = t.mask; in_a_data = t.data;
    in_a_corrupt = t.corrupt;
    a_q.push_back(t);
  endtask

  task automatic drop_a();
    in_a_valid = 1'b0;
    if (a_q.size() > 0) void'(a_q.pop_back());
  endtask

  task automatic set_d(input logic [2:0] op, input logic [2:0] size, input logic [4:0] src);
    d_t t;
    t = '{op: op, param: 2'd0, size: size, src: src, sink: 1'b0, denied: 1'b0,
          data: 64'({8'hD0, 3'(op), src}), corrupt: 1'b0};
    out_d_valid = 1'b1; out_d_opcode = t.op; out_d_param = t.param; out_d_size = t.size;
    out_d_source = t.src; out_d_sink = t.sink; out_d_denied = t.denied; out_d_data = t.data;
    out_d_corrupt = t.corrupt;
    d_q.push_back(t);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Check A ready for the beat currently presented, then advance one cycle.
  task automatic cyc(input logic exp_rdy, input string name);
    #1 check(name, in_a_ready, exp_rdy);
    @(negedge clock);
  endtask

  initial forever begin
    @(negedge clock);
    #2;
    if (reset && out_a_valid && out_a_ready) begin
      got_a = '{out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address,
                out_a_mask, out_a_data, out_a_corrupt};
      tests++;
      if (a_q.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected: got %h, required no beat", got_a);
      end else begin
        exp_a = a_q.pop_front();
        if (got_a !== exp_a) begin
          fails++;
          $display("FAIL a_payload: got %h, required %h", got_a, exp_a);
        end
      end
    end
    if (reset && in_d_valid && in_d_ready) begin
      got_d = '{in_d_opcode, in_d_param, in_d_size, in_d_source, in_d_sink,
                in_d_denied, in_d_data, in_d_corrupt};
      tests++;
      if (d_q.size() == 0) begin
        fails++;
        $display("FAIL d_unexpected: got %h, required no beat", got_d);
      end else begin
        exp_d = d_q.pop_front();
        if (got_d !== exp_d) begin
          fails++;
          $display("FAIL d_payload: got %h, required %h", got_d, exp_d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in_a_valid = 0; in_a_opcode = 0; in_a_param = 0; in_a_size = 0; in_a_source = 0;
    in_a_address = 0; in_a_mask = 0; in_a_data = 0; in_a_corrupt = 0;
    out_d_valid = 0; out_d_opcode = 0; out_d_param = 0; out_d_size = 0; out_d_source = 0;
    out_d_sink = 0; out_d_denied = 0; out_d_data = 0; out_d_corrupt = 0;
    out_a_ready = 1'b0; in_d_ready = 1'b1;
    #2 in_a_valid = 1'b1;
    #1 check("rst_valid_follow", out_a_valid, 1'b1);
    check("rst_ready_low", in_a_ready, 1'b0);
    out_a_ready = 1'b1;
    #1 check("rst_ready_follow", in_a_ready, 1'b1);
`ifdef TL_FIFO_FIXER_PERF_EN
    check("rst_perf", perf, 32'd0);
`endif
    in_a_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Single Get src 2 to domain 1, then a domain-0 Get held until the response.
    set_a(3'd4, 3'd3, 5'd2, 31'h1000_0000); cyc(1'b1, "get_src2_pass");
    set_a(3'd4, 3'd3, 5'd2, 31'h0000_0000); cyc(1'b0, "src2_dom_stall");
    set_d(3'd1, 3'd3, 5'd2);                cyc(1'b0, "src2_same_cycle_as_d");
    out_d_valid = 1'b0;                     cyc(1'b1, "src2_release");
    in_a_valid = 1'b0; set_d(3'd1, 3'd3, 5'd2); step(); out_d_valid = 1'b0;

    // Per-source tracking: src 4 unaffected by src 3's outstanding domain.
    set_a(3'd4, 3'd3, 5'd3, 31'h0000_0000); cyc(1'b1, "src3_dom0");
    set_a(3'd4, 3'd3, 5'd4, 31'h2000_0000); cyc(1'b1, "src4_other_source");
    set_a(3'd4, 3'd3, 5'd3, 31'h2000_0000);
    for (int i = 0; i < 3; i++) cyc(1'b0, "src3_dom2_stall");
    set_d(3'd1, 3'd3, 5'd3);                cyc(1'b0, "src3_stall_d_cycle");
    out_d_valid = 1'b0;                     cyc(1'b1, "src3_release");
    in_a_valid = 1'b0;
    set_d(3'd1, 3'd3, 5'd4); step(); set_d(3'd1, 3'd3, 5'd3); step(); out_d_valid = 1'b0;

    // In-flight saturation at seven.
    for (int i = 0; i < 7; i++) begin
      set_a(3'd4, 3'd3, 5'd1, 31'(i * 256)); cyc(1'b1, "src1_fill");
    end
    set_a(3'd4, 3'd3, 5'd1, 31'h0000_0800);
    cyc(1'b0, "src1_full_stall"); cyc(1'b0, "src1_full_stall");
    set_d(3'd1, 3'd3, 5'd1);                cyc(1'b0, "src1_full_d_cycle");
    out_d_valid = 1'b0;                     cyc(1'b1, "src1_8th_release");
    in_a_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin set_d(3'd1, 3'd3, 5'd1); step(); end
    out_d_valid = 1'b0;

    // Response to an idle source must not wrap the count.
    set_d(3'd0, 3'd0, 5'd5); step(); out_d_valid = 1'b0;
    set_a(3'd4, 3'd3, 5'd5, 31'h1000_0000); cyc(1'b1, "src5_after_spurious_d");
    in_a_valid = 1'b0; set_d(3'd1, 3'd3, 5'd5); step(); out_d_valid = 1'b0;

    // 8-beat PutFull: only the first beat is subject to stall.
    set_a(3'd4, 3'd3, 5'd6, 31'h1000_0000); cyc(1'b1, "src6_get_dom1");
    set_a(3'd0, 3'd6, 5'd6, 31'h0000_0000); cyc(1'b0, "put_first_stall");
    set_d(3'd1, 3'd3, 5'd6);                cyc(1'b0, "put_first_d_cycle");
    out_d_valid = 1'b0;                     cyc(1'b1, "put_beat0");
    for (int i = 1; i < 8; i++) begin
      set_a(3'd0, 3'd6, 5'd6, 31'h1000_0000 + 31'(i * 8)); cyc(1'b1, "put_beat_n");
    end
    set_a(3'd4, 3'd3, 5'd6, 31'h1000_0000); cyc(1'b0, "after_burst_is_first");
    set_d(3'd0, 3'd6, 5'd6);                cyc(1'b0, "put_ack_d_cycle");
    out_d_valid = 1'b0;                     cyc(1'b1, "put_ack_release");
    in_a_valid = 1'b0; set_d(3'd1, 3'd3, 5'd6); step(); out_d_valid = 1'b0;

    // 4-beat AccessAckData decrements only on its last beat.
    set_a(3'd4, 3'd5, 5'd7, 31'h0000_0000); cyc(1'b1, "src7_get32");
    set_a(3'd4, 3'd3, 5'd7, 31'h1000_0000);
    for (int i = 0; i < 4; i++) begin
      set_d(3'd1, 3'd5, 5'd7); cyc(1'b0, "d_burst_hold");
    end
    out_d_valid = 1'b0;                     cyc(1'b1, "d_burst_release");
    in_a_valid = 1'b0; set_d(3'd1, 3'd3, 5'd7); step(); out_d_valid = 1'b0;

    // ReleaseAck does not retire a request.
    set_a(3'd4, 3'd3, 5'd8, 31'h0000_0000); cyc(1'b1, "src8_get");
    set_a(3'd4, 3'd3, 5'd8, 31'h1000_0000); cyc(1'b0, "src8_stall");
    set_d(3'd6, 3'd0, 5'd8);                cyc(1'b0, "src8_releaseack_cycle");
    out_d_valid = 1'b0;                     cyc(1'b0, "releaseack_no_dec");
    set_d(3'd0, 3'd0, 5'd8);                cyc(1'b0, "src8_ack_cycle");
    out_d_valid = 1'b0;                     cyc(1'b1, "src8_release");
    in_a_valid = 1'b0; set_d(3'd1, 3'd3, 5'd8); step(); out_d_valid = 1'b0;

    // Reset in the middle of a burst clears counts and beat position.
    set_a(3'd4, 3'd3, 5'd10, 31'h1000_0000); cyc(1'b1, "src10_get");
    set_a(3'd0, 3'd6, 5'd9, 31'h0000_0000);  cyc(1'b1, "burst_beat0");
    set_a(3'd0, 3'd6, 5'd9, 31'h0000_0000);  cyc(1'b1, "burst_beat1");
    in_a_valid = 1'b0;
    #2 reset = 1'b0;
`ifdef TL_FIFO_FIXER_PERF_EN
    #1 check("perf_cleared", perf, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
    set_a(3'd4, 3'd3, 5'd10, 31'h2000_0000); cyc(1'b1, "src10_cleared");
    set_a(3'd4, 3'd3, 5'd9, 31'h1000_0000);  cyc(1'b1, "first_after_reset");
    set_a(3'd4, 3'd3, 5'd9, 31'h2000_0000);
    for (int i = 0; i < 5; i++) cyc(1'b0, "post_reset_tracked");
`ifdef TL_FIFO_FIXER_PERF_EN
    #1 check("perf_five", perf, 32'd5);
`endif
    drop_a();
    step(); step();
    check("a_queue_empty", 64'(a_q.size()), 64'd0);
    check("d_queue_empty", 64'(d_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
